// File: rtl/flash_arbiter.sv
// flash_arbiter: two-requester (audio, graphics) arbiter for a byte-wide parallel flash.
// Each transaction reads one 16-bit word as two byte reads: the low byte at the latched
// address and the high byte at address+1. Address+1 wraps modulo 2^23.
//
// Ports:
//   Clock_50              system clock; all state updates on its rising edge
//   reset_h               asynchronous active-high reset
//   aud_req/aud_addr      audio request (level, held until ack) and word byte address
//   aud_ack/aud_data      one-cycle ack pulse; data = {byte@addr+1, byte@addr}, held until next ack
//   gfx_*                 same as aud_* for the graphics requester
//   busy                  high while a transaction is in progress
//   FL_RY                 flash ready (high = ready), only looked at when idle
//   FL_DQ                 flash data bus, only ever read
//   FL_ADDR               flash byte address
//   FL_CE_N/FL_OE_N       active-low chip/output enable, asserted during both byte reads
//   FL_WE_N/FL_RST_N/FL_WP_N  tied high
module flash_arbiter #(
  parameter int unsigned READ_WAIT = 5  // clock cycles per flash byte access, 1..15
) (
  input  logic        Clock_50,
  input  logic        reset_h,
  input  logic        aud_req,
  input  logic [22:0] aud_addr,
  output logic        aud_ack,
  output logic [15:0] aud_data,
  input  logic        gfx_req,
  input  logic [22:0] gfx_addr,
  output logic        gfx_ack,
  output logic [15:0] gfx_data,
  output logic        busy,
  input  logic        FL_RY,
  inout  wire  [7:0]  FL_DQ,
  output logic [22:0] FL_ADDR,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic        FL_WP_N
);

  localparam logic [3:0] WaitLast = 4'(READ_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic        owner_q, owner_d;      // 1 = graphics owns the current transaction
  logic [1:0]  starve_q, starve_d;    // audio grants made while graphics was waiting
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [15:0] aud_data_q, aud_data_d;
  logic [15:0] gfx_data_q, gfx_data_d;
  logic        aud_ack_q, aud_ack_d;
  logic        gfx_ack_q, gfx_ack_d;
  logic        grant_gfx;
  logic        reading;

  // Graphics wins when it is alone, or once it has lost twice in a row to audio.
  assign grant_gfx = gfx_req && (!aud_req || (starve_q == 2'd2));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    lo_byte_d  = lo_byte_q;
    aud_data_d = aud_data_q;
    gfx_data_d = gfx_data_q;
    aud_ack_d  = 1'b0;
    gfx_ack_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (FL_RY && (aud_req || gfx_req)) begin
          state_d = StLo;
          cnt_d   = 4'd0;
          owner_d = grant_gfx;
          addr_d  = grant_gfx ? gfx_addr : aud_addr;
          if (grant_gfx) begin
            starve_d = 2'd0;
          end else if (gfx_req && (starve_q != 2'd2)) begin
            starve_d = starve_q + 2'd1;
          end
        end
      end
      StLo: begin
        if (cnt_q == WaitLast) begin
          cnt_d     = 4'd0;
          lo_byte_d = FL_DQ;
          state_d   = StHi;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHi: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = 4'd0;
          state_d = StDone;
          // Data and ack register together so both are valid throughout DONE.
          if (owner_q) begin
            gfx_data_d = {FL_DQ, lo_byte_q};
            gfx_ack_d  = 1'b1;
          end else begin
            aud_data_d = {FL_DQ, lo_byte_q};
            aud_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock_50 or posedge reset_h) begin
    if (reset_h) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= 23'd0;
      owner_q    <= 1'b0;
      starve_q   <= 2'd0;
      lo_byte_q  <= 8'd0;
      aud_data_q <= 16'd0;
      gfx_data_q <= 16'd0;
      aud_ack_q  <= 1'b0;
      gfx_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      lo_byte_q  <= lo_byte_d;
      aud_data_q <= aud_data_d;
      gfx_data_q <= gfx_data_d;
      aud_ack_q  <= aud_ack_d;
      gfx_ack_q  <= gfx_ack_d;
    end
  end

  // Flash strobes decode straight from state so an async reset releases them at once.
  assign reading  = (state_q == StLo) || (state_q == StHi);
  assign busy     = (state_q != StIdle);
  assign FL_CE_N  = !reading;
  assign FL_OE_N  = !reading;
  assign FL_ADDR  = (state_q == StHi) ? (addr_q + 23'd1) : addr_q;
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = 1'b1;
  assign FL_WP_N  = 1'b1;

  assign aud_ack  = aud_ack_q;
  assign gfx_ack  = gfx_ack_q;
  assign aud_data = aud_data_q;
  assign gfx_data = gfx_data_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a scoreboard of expected acks (owner + word).
module tb_flash_arbiter;

  localparam int W = 5;

  logic        clk;
  logic        reset_h;
  logic        aud_req, gfx_req;
  logic [22:0] aud_addr, gfx_addr;
  logic        aud_ack, gfx_ack;
  logic [15:0] aud_data, gfx_data;
  logic        busy;
  logic        fl_ry;
  wire  [7:0]  fl_dq;
  logic [22:0] fl_addr;
  logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n, fl_wp_n;

  typedef struct packed {
    logic        gfx;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_aud = 16'd0;
  logic [15:0] exp_gfx = 16'd0;

  flash_arbiter #(.READ_WAIT(W)) dut (
    .Clock_50(clk),
    .reset_h (reset_h),
    .aud_req (aud_req),
    .aud_addr(aud_addr),
    .aud_ack (aud_ack),
    .aud_data(aud_data),
    .gfx_req (gfx_req),
    .gfx_addr(gfx_addr),
    .gfx_ack (gfx_ack),
    .gfx_data(gfx_data),
    .busy    (busy),
    .FL_RY   (fl_ry),
    .FL_DQ   (fl_dq),
    .FL_ADDR (fl_addr),
    .FL_CE_N (fl_ce_n),
    .FL_OE_N (fl_oe_n),
    .FL_WE_N (fl_we_n),
    .FL_RST_N(fl_rst_n),
    .FL_WP_N (fl_wp_n)
  );

  // Flash contents: two fixed bytes, everything else a hash of the address.
  function automatic logic [7:0] fbyte(input logic [22:0] a);
    if (a == 23'h000100) return 8'h34;
    if (a == 23'h000101) return 8'h12;
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'hA5;
  endfunction

  function automatic logic [15:0] fword(input logic [22:0] a);
    logic [22:0] a1;
    a1 = a + 23'd1;
    return {fbyte(a1), fbyte(a)};
  endfunction

  assign fl_dq = fbyte(fl_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic gfx, input logic [22:0] a);
    exp_t e;
    e.gfx  = gfx;
    e.data = fword(a);
    sb.push_back(e);
  endtask

  // Waits for an ack; cyc is the number of negedges elapsed. Pops and checks the scoreboard.
  task automatic wait_ack(input int budget, output int cyc);
    exp_t e;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(aud_ack || gfx_ack) && cyc < budget);
    if (!(aud_ack || gfx_ack)) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_ack", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ack_owner", {30'd0, aud_ack, gfx_ack}, e.gfx ? 32'd1 : 32'd2);
      if (e.gfx) exp_gfx = e.data;
      else exp_aud = e.data;
      check("aud_data", aud_data, exp_aud);
      check("gfx_data", gfx_data, exp_gfx);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ce_oe"}, {fl_ce_n, fl_oe_n}, 2'b11);
    check({tag, "_addr"}, fl_addr, 0);
    check({tag, "_acks"}, {aud_ack, gfx_ack}, 0);
    check({tag, "_data"}, {aud_data, gfx_data}, 0);
  endtask

  initial begin
    int c;
    int gap;
    logic ok;

    reset_h  = 1'b1;
    aud_req  = 1'b0;
    gfx_req  = 1'b0;
    aud_addr = 23'd0;
    gfx_addr = 23'd0;
    fl_ry    = 1'b1;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    check("const_pins", {fl_we_n, fl_rst_n, fl_wp_n}, 3'b111);
    reset_h = 1'b0;
    tick();

    // Single audio read with exact latency
    aud_req  = 1'b1;
    aud_addr = 23'h000100;
    push(1'b0, 23'h000100);
    tick();
    check("lo_addr", fl_addr, 23'h000100);
    check("lo_ce_oe", {fl_ce_n, fl_oe_n}, 2'b00);
    check("lo_busy", busy, 1);
    wait_ack(40, c);
    check("single_latency", c + 1, 2 * W + 1);
    check("single_word", aud_data, 16'h1234);
    check("done_ce_oe", {fl_ce_n, fl_oe_n}, 2'b11);
    aud_req = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("ack_one_cycle", {aud_ack, gfx_ack}, 0);
    check("idle_addr_hold", fl_addr, 23'h000100);

    // Graphics read across the address wrap
    gfx_req  = 1'b1;
    gfx_addr = 23'h7FFFFF;
    push(1'b1, 23'h7FFFFF);
    tick();
    check("wrap_lo_addr", fl_addr, 23'h7FFFFF);
    repeat (W) tick();
    check("wrap_hi_addr", fl_addr, 23'h000000);
    check("wrap_hi_ce", fl_ce_n, 0);
    wait_ack(40, c);
    check("wrap_latency", c + W + 1, 2 * W + 1);
    check("wrap_word", gfx_data, {fbyte(23'h000000), fbyte(23'h7FFFFF)});
    gfx_req = 1'b0;
    tick();

    // Flash not ready: no grant until FL_RY rises; FL_RY ignored once running
    fl_ry    = 1'b0;
    aud_req  = 1'b1;
    aud_addr = 23'h000ABC;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (busy || !fl_ce_n) ok = 1'b0;
    end
    check("busy_flash_no_grant", ok, 1);
    push(1'b0, 23'h000ABC);
    fl_ry = 1'b1;
    tick();
    check("ry_rise_lo", {busy, fl_ce_n}, 2'b10);
    fl_ry = 1'b0;
    wait_ack(40, c);
    check("ry_ignored_latency", c + 1, 2 * W + 1);
    aud_req = 1'b0;
    fl_ry   = 1'b1;
    tick();

    // Request dropped and address changed mid-transaction
    aud_req  = 1'b1;
    aud_addr = 23'h012345;
    push(1'b0, 23'h012345);
    tick();
    aud_req  = 1'b0;
    aud_addr = 23'h000777;
    wait_ack(40, c);
    check("drop_latency", c + 1, 2 * W + 1);
    tick();
    check("drop_idle", {busy, aud_ack}, 0);
    tick();
    check("drop_no_regrant", busy, 0);

    // Contention: audio, audio, graphics, repeating
    aud_req  = 1'b1;
    aud_addr = 23'h000200;
    gfx_req  = 1'b1;
    gfx_addr = 23'h3ABCDE;
    for (int r = 0; r < 2; r++) begin
      push(1'b0, 23'h000200);
      push(1'b0, 23'h000200);
      push(1'b1, 23'h3ABCDE);
    end
    gap = 0;
    for (int i = 0; i < 6; i++) begin
      wait_ack(40, c);
      check("contend_spacing", c, (i == 0) ? 2 * W + 1 : 2 * W + 2);
      if (i >= 3) gap += c;
    end
    check("gfx_ack_gap", gap, 3 * (2 * W + 2));
    aud_req = 1'b0;
    gfx_req = 1'b0;
    tick();
    check("contend_end_idle", busy, 0);

    // Reset pulsed during HI aborts; held request is served afterward
    aud_req  = 1'b1;
    aud_addr = 23'h055AA0;
    push(1'b0, 23'h055AA0);
    tick();
    repeat (W) tick();
    check("abort_hi_addr", fl_addr, 23'h055AA1);
    reset_h = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_aud = 16'd0;
    exp_gfx = 16'd0;
    tick();
    check("abort_no_ack", {aud_ack, gfx_ack}, 0);
    reset_h = 1'b0;
    wait_ack(40, c);
    check("after_abort_latency", c, 2 * W + 1);
    aud_req = 1'b0;
    tick();
    check("final_idle", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 The module SHALL have parameter READ_WAIT, default 5, meaning clock cycles per flash byte access (legal range 1..15).
REQ-002 The module SHALL have port Clock_50  in  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_h  in  1  reset; asynchronous, active-high.
REQ-004 The module SHALL have port aud_req  in  1  audio requester read request, level, held until aud_ack.
REQ-005 The module SHALL have port aud_addr  in  23  audio byte address of the 16-bit word; low byte sits at aud_addr.
REQ-006 The module SHALL have port aud_ack  out  1  one-cycle pulse; aud_data valid this cycle.
REQ-007 The module SHALL have port aud_data  out  16  audio word, {byte@addr+1, byte@addr}.
REQ-008 The module SHALL have ports gfx_req, gfx_addr, gfx_ack and gfx_data with the same directions, widths and meanings as the audio ports, for the graphics requester.
REQ-009 The module SHALL have port busy  out  1  high while a flash transaction is in progress.
REQ-010 The module SHALL have port FL_RY  in  1  flash ready; high means ready.
REQ-011 The module SHALL have port FL_DQ  inout  8  flash data bus; never driven, always high-Z.
REQ-012 The module SHALL have port FL_ADDR  out  23  flash byte address.
REQ-013 The module SHALL have ports FL_CE_N and FL_OE_N  out  1 each  active-low chip enable and output enable.
REQ-014 The module SHALL have ports FL_WE_N, FL_RST_N and FL_WP_N  out  1 each  constant 1.

Function
REQ-015 The module SHALL implement states IDLE, LO, HI and DONE; one transaction reads one 16-bit word as two byte reads.
REQ-016 In IDLE, the module SHALL grant only when FL_RY=1 and at least one request is high, latching the address and owner at that edge and moving to LO.
REQ-017 Arbitration: audio SHALL win by default; graphics SHALL win if gfx_starve=2.
REQ-018 gfx_starve (2 bits) SHALL increment on every audio grant made while gfx_req=1, SHALL clear on every graphics grant, and SHALL saturate at 2.
REQ-019 In LO, FL_CE_N and FL_OE_N SHALL be 0 and FL_ADDR SHALL equal the latched address; the module SHALL stay READ_WAIT cycles, sample FL_DQ into the low byte on the last cycle, then go to HI.
REQ-020 In HI, FL_CE_N and FL_OE_N SHALL remain 0 and FL_ADDR SHALL equal the latched address+1, wrapping modulo 2^23 (7FFFFF -> 000000); the module SHALL stay READ_WAIT cycles, sample FL_DQ into the high byte on the last cycle, then go to DONE.
REQ-021 In DONE, FL_CE_N and FL_OE_N SHALL be 1, the owner's ack SHALL be 1 for exactly one cycle with its data register updated that same cycle, and the next state SHALL be IDLE.
REQ-022 In IDLE and DONE, FL_CE_N and FL_OE_N SHALL be 1 and FL_ADDR SHALL hold the last latched address.
REQ-023 Latency: ack SHALL be high in the cycle 2*READ_WAIT+1 clocks after the granting edge (11 clocks at default).
REQ-024 Back-to-back throughput SHALL be at most one word per 2*READ_WAIT+2 clocks, with re-arbitration in every IDLE cycle.
REQ-025 A request dropped mid-transaction SHALL NOT abort the transaction; the ack still pulses.
REQ-026 Request or address changes after the grant SHALL NOT affect the transaction in progress.
REQ-027 FL_RY SHALL be ignored outside IDLE.
REQ-028 busy SHALL be 1 in LO, HI and DONE, and 0 in IDLE.
REQ-029 Each data output SHALL hold its value until that requester's next ack; the other requester's data output SHALL be unaffected.

Reset
REQ-030 While reset_h=1, the module SHALL force state=IDLE, gfx_starve=0, counter=0, latched address=0, aud_data=gfx_data=0, aud_ack=gfx_ack=0, busy=0, FL_CE_N=FL_OE_N=1 and FL_ADDR=0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction immediately with no ack; after release, the first grant SHALL occur only from IDLE.

Verification
REQ-032 Single read: flash bytes 0x34@0x000100 and 0x12@0x000101, aud_req with aud_addr=0x000100 -> aud_ack exactly 11 clocks after the grant edge, aud_data=0x1234, gfx_data=0.
REQ-033 Contention: aud_req and gfx_req held continuously -> grant order audio, audio, graphics, repeating; each gfx ack gap = 3 transactions = 36 clocks.
REQ-034 Wrap: gfx_addr=0x7FFFFF -> FL_ADDR=0x7FFFFF in LO then 0x000000 in HI; gfx_data={byte@0, byte@7FFFFF}.
REQ-035 Busy flash: FL_RY=0 with aud_req=1 for 20 clocks -> no grant, FL_CE_N=1; FL_RY rises -> LO entered on the next edge.
REQ-036 Reset abort: reset_h pulsed in HI -> FL_CE_N and FL_OE_N immediately 1, no ack, outputs at reset values; a pending request is served cleanly afterward.
REQ-037 Dropped request: aud_req deasserted during LO -> aud_ack still pulses with correct data, followed by return to IDLE.
